// File: rtl/jkff_pkg.sv
// jkff_pkg
// Shared definitions for the JK flip-flop monitor: J/K mode encoding,
// monitor FSM state type and the JK characteristic function.
// No ports; imported by jkff_monitor and jkff_sat_cnt.
package jkff_pkg;

  // {J,K} as applied to the monitored flip-flop
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_RST  = 2'b01,
    MODE_SET  = 2'b10,
    MODE_TGL  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Next Q of a JK flip-flop given its current Q and inputs
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic nq;
    case (mode_t'({j, k}))
      MODE_HOLD: nq = q;
      MODE_RST:  nq = 1'b0;
      MODE_SET:  nq = 1'b1;
      default:   nq = ~q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/jkff_sat_cnt.sv
// jkff_sat_cnt
// Saturating up-counter used for the monitor's mode, error and cycle counts.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-low reset
//   clr  - synchronous clear; wins over inc at the same edge
//   inc  - count enable for this edge
//   cnt  - current count, sticks at all-ones
module jkff_sat_cnt
  import jkff_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // clr before inc so an event at a clearing edge is dropped
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/jkff_monitor.sv
// jkff_monitor
// Passive checker for a JK flip-flop. Predicts the next Q from the sampled
// J, K, reset and observed Q, compares on the following edge, counts applied
// modes and captures the first mismatch.
// Ports:
//   clk, rst        - clock and synchronous active-low reset of the monitor
//   en              - checking enable (low forces IDLE)
//   clr             - synchronous clear of counters and first-error capture
//   dut_rst, J, K, Q - monitored flip-flop reset, inputs and output
//   err_pulse       - one-cycle pulse per mismatch
//   err_sticky      - set on first mismatch until rst/clr
//   err_cnt         - saturating mismatch count
//   cnt_hold/reset/set/toggle - saturating counts of J/K = 00/01/10/11
//   cyc_cnt         - saturating count of CHECK edges
//   fe_valid, fe_cycle, fe_exp - first-error capture
module jkff_monitor
  import jkff_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int CYC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             dut_rst,
  input  logic             J,
  input  logic             K,
  input  logic             Q,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] cnt_hold,
  output logic [CNT_W-1:0] cnt_reset,
  output logic [CNT_W-1:0] cnt_set,
  output logic [CNT_W-1:0] cnt_toggle,
  output logic [CYC_W-1:0] cyc_cnt,
  output logic             fe_valid,
  output logic [CYC_W-1:0] fe_cycle,
  output logic             fe_exp
);

  state_t state;
  state_t phase;
  logic   exp_q;
  logic   active;
  logic   checking;
  logic   mismatch;
  logic   mode_inc;
  mode_t  mode;

  // The state register holds the role of the last edge, so "phase" is the
  // role of the coming edge: the first enabled edge primes, later ones check.
  always_comb begin
    phase = IDLE;
    if (en) begin
      phase = (state == IDLE) ? PRIME : CHECK;
    end
  end

  assign active   = (phase != IDLE);
  assign checking = (phase == CHECK);
  assign mismatch = checking && (Q != exp_q);
  assign mode_inc = active && !dut_rst;
  assign mode     = mode_t'({J, K});

  // Prediction is built from the observed Q, so one corrupted sample
  // produces exactly one error instead of a cascade.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      exp_q      <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      fe_valid   <= 1'b0;
      fe_cycle   <= '0;
      fe_exp     <= 1'b0;
    end else begin
      state     <= phase;
      err_pulse <= mismatch;
      if (active) begin
        exp_q <= dut_rst ? 1'b0 : jk_next(Q, J, K);
      end
      if (clr) begin
        err_sticky <= 1'b0;
        fe_valid   <= 1'b0;
        fe_cycle   <= '0;
        fe_exp     <= 1'b0;
      end else if (mismatch) begin
        err_sticky <= 1'b1;
        if (!fe_valid) begin
          fe_valid <= 1'b1;
          fe_cycle <= cyc_cnt;
          fe_exp   <= exp_q;
        end
      end
    end
  end

  jkff_sat_cnt #(.W(CNT_W)) u_cnt_hold (
    .clk(clk), .rst(rst), .clr(clr),
    .inc(mode_inc && (mode == MODE_HOLD)), .cnt(cnt_hold)
  );

  jkff_sat_cnt #(.W(CNT_W)) u_cnt_reset (
    .clk(clk), .rst(rst), .clr(clr),
    .inc(mode_inc && (mode == MODE_RST)), .cnt(cnt_reset)
  );

  jkff_sat_cnt #(.W(CNT_W)) u_cnt_set (
    .clk(clk), .rst(rst), .clr(clr),
    .inc(mode_inc && (mode == MODE_SET)), .cnt(cnt_set)
  );

  jkff_sat_cnt #(.W(CNT_W)) u_cnt_toggle (
    .clk(clk), .rst(rst), .clr(clr),
    .inc(mode_inc && (mode == MODE_TGL)), .cnt(cnt_toggle)
  );

  jkff_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk(clk), .rst(rst), .clr(clr),
    .inc(mismatch), .cnt(err_cnt)
  );

  jkff_sat_cnt #(.W(CYC_W)) u_cyc_cnt (
    .clk(clk), .rst(rst), .clr(clr),
    .inc(checking), .cnt(cyc_cnt)
  );

endmodule

// File: tb/tb_jkff_monitor.sv
// tb_jkff_monitor
// Directed bench for jkff_monitor. A behavioural JK flip-flop drives the
// monitor; its observed Q can be inverted for single cycles to inject faults.
// A second monitor instance with CNT_W=2 shares all inputs for saturation.
module tb_jkff_monitor;

  localparam int CNT_W = 8;
  localparam int CYC_W = 16;

  typedef enum {
    F_PULSE, F_STICKY, F_ERRCNT, F_HOLD, F_RESET, F_SET, F_TGL,
    F_CYC, F_FEV, F_FECYC, F_FEEXP, F_SATHOLD, F_SATTGL
  } field_t;

  typedef struct {
    int     cyc;
    field_t f;
    int     val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic dut_rst = 1'b0;
  logic J = 1'b0;
  logic K = 1'b0;
  logic inj = 1'b0;
  logic ff_q = 1'b0;
  logic Q;

  logic             err_pulse, err_sticky, fe_valid, fe_exp;
  logic [CNT_W-1:0] err_cnt, cnt_hold, cnt_reset, cnt_set, cnt_toggle;
  logic [CYC_W-1:0] cyc_cnt, fe_cycle;

  logic             s_err_pulse, s_err_sticky, s_fe_valid, s_fe_exp;
  logic [1:0]       s_err_cnt, s_cnt_hold, s_cnt_reset, s_cnt_set, s_cnt_toggle;
  logic [CYC_W-1:0] s_cyc_cnt, s_fe_cycle;

  exp_t sb[$];
  int   edge_no = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  assign Q = ff_q ^ inj;

  always #10 clk = ~clk;

  // Reference flip-flop standing in for jkff_nbk
  always @(posedge clk) begin
    if (dut_rst) ff_q <= 1'b0;
    else begin
      case ({J, K})
        2'b00: ff_q <= ff_q;
        2'b01: ff_q <= 1'b0;
        2'b10: ff_q <= 1'b1;
        default: ff_q <= ~ff_q;
      endcase
    end
  end

  jkff_monitor #(.CNT_W(CNT_W), .CYC_W(CYC_W)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .dut_rst(dut_rst),
    .J(J), .K(K), .Q(Q),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .err_cnt(err_cnt),
    .cnt_hold(cnt_hold), .cnt_reset(cnt_reset), .cnt_set(cnt_set),
    .cnt_toggle(cnt_toggle), .cyc_cnt(cyc_cnt), .fe_valid(fe_valid),
    .fe_cycle(fe_cycle), .fe_exp(fe_exp)
  );

  jkff_monitor #(.CNT_W(2), .CYC_W(CYC_W)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .dut_rst(dut_rst),
    .J(J), .K(K), .Q(Q),
    .err_pulse(s_err_pulse), .err_sticky(s_err_sticky), .err_cnt(s_err_cnt),
    .cnt_hold(s_cnt_hold), .cnt_reset(s_cnt_reset), .cnt_set(s_cnt_set),
    .cnt_toggle(s_cnt_toggle), .cyc_cnt(s_cyc_cnt), .fe_valid(s_fe_valid),
    .fe_cycle(s_fe_cycle), .fe_exp(s_fe_exp)
  );

  function automatic logic [31:0] actual(input field_t f);
    logic [31:0] a;
    a = '0;
    case (f)
      F_PULSE:   a = 32'(err_pulse);
      F_STICKY:  a = 32'(err_sticky);
      F_ERRCNT:  a = 32'(err_cnt);
      F_HOLD:    a = 32'(cnt_hold);
      F_RESET:   a = 32'(cnt_reset);
      F_SET:     a = 32'(cnt_set);
      F_TGL:     a = 32'(cnt_toggle);
      F_CYC:     a = 32'(cyc_cnt);
      F_FEV:     a = 32'(fe_valid);
      F_FECYC:   a = 32'(fe_cycle);
      F_FEEXP:   a = 32'(fe_exp);
      F_SATHOLD: a = 32'(s_cnt_hold);
      default:   a = 32'(s_cnt_toggle);
    endcase
    return a;
  endfunction

  // Monitor: after each rising edge, pop and compare every expectation
  // scheduled for that edge.
  initial begin
    exp_t        item;
    logic [31:0] act;
    forever begin
      @(posedge clk);
      edge_no++;
      #2;
      while (sb.size() > 0 && sb[0].cyc <= edge_no) begin
        item = sb.pop_front();
        act = actual(item.f);
        tests_run++;
        if (act !== 32'(item.val)) begin
          tests_failed++;
          $display("[TB] FAIL %s edge %0d: got %0d, expected %0d",
                   item.f.name(), edge_no, act, item.val);
        end
      end
    end
  end

  // Drive inputs at the falling edge so the next rising edge samples them
  task automatic applyStimulus(input logic r, input logic e, input logic c,
                               input logic dr, input logic j, input logic k,
                               input logic fault);
    @(negedge clk);
    rst = r; en = e; clr = c; dut_rst = dr; J = j; K = k; inj = fault;
  endtask

  // Expectation for outputs after the edge following the last applyStimulus
  task automatic checkOutput(input field_t f, input int val);
    exp_t item;
    item.cyc = edge_no + 1;
    item.f   = f;
    item.val = val;
    sb.push_back(item);
  endtask

  task automatic step(input logic r, input logic e, input logic c,
                      input logic dr, input logic j, input logic k,
                      input logic fault, input int pulse);
    applyStimulus(r, e, c, dr, j, k, fault);
    checkOutput(F_PULSE, pulse);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    step(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput(F_STICKY, 0); checkOutput(F_ERRCNT, 0); checkOutput(F_HOLD, 0);
    checkOutput(F_CYC, 0);    checkOutput(F_FEV, 0);

    // Clean run: dut_rst for two edges, then each mode for two edges
    step(1, 1, 0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1, 1, 0, 0);
    step(1, 1, 0, 0, 1, 1, 0, 0);
    checkOutput(F_ERRCNT, 0); checkOutput(F_HOLD, 2); checkOutput(F_RESET, 2);
    checkOutput(F_SET, 2);    checkOutput(F_TGL, 2);  checkOutput(F_FEV, 0);
    checkOutput(F_CYC, 9);

    // Single fault under J/K=10 at CHECK cycle index 10
    step(1, 1, 0, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1, 0, 1, 1);
    checkOutput(F_ERRCNT, 1); checkOutput(F_STICKY, 1); checkOutput(F_FEV, 1);
    checkOutput(F_FEEXP, 1);  checkOutput(F_FECYC, 10);
    step(1, 1, 0, 0, 1, 0, 0, 0);
    checkOutput(F_ERRCNT, 1); checkOutput(F_FECYC, 10);

    // Clear everything before the toggle chain
    step(1, 1, 1, 0, 0, 0, 0, 0);
    checkOutput(F_ERRCNT, 0); checkOutput(F_STICKY, 0); checkOutput(F_FEV, 0);
    checkOutput(F_CYC, 0);    checkOutput(F_SET, 0);

    // Toggle chain
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 1, 1, 0, 0);
    checkOutput(F_TGL, 10); checkOutput(F_ERRCNT, 0); checkOutput(F_CYC, 10);
    checkOutput(F_SATTGL, 3);

    // Saturation of the 2-bit instance
    for (int i = 1; i <= 6; i++) begin
      step(1, 1, 0, 0, 0, 0, 0, 0);
      if (i == 3) checkOutput(F_SATHOLD, 3);
    end
    checkOutput(F_SATHOLD, 3); checkOutput(F_HOLD, 6);

    // clr colliding with a mismatch
    step(1, 1, 1, 0, 1, 0, 1, 1);
    checkOutput(F_ERRCNT, 0); checkOutput(F_STICKY, 0); checkOutput(F_FEV, 0);
    checkOutput(F_SET, 0);
    step(1, 1, 0, 0, 1, 0, 0, 0);
    checkOutput(F_SET, 1); checkOutput(F_ERRCNT, 0);

    // Mid-run reset
    step(0, 1, 0, 0, 1, 0, 0, 0);
    checkOutput(F_SET, 0); checkOutput(F_CYC, 0);  checkOutput(F_HOLD, 0);
    checkOutput(F_TGL, 0); checkOutput(F_STICKY, 0);
    // First edge after reset primes only: injected fault is not compared
    step(1, 1, 0, 0, 1, 0, 1, 0);
    checkOutput(F_SET, 1); checkOutput(F_CYC, 0); checkOutput(F_ERRCNT, 0);
    step(1, 1, 0, 0, 1, 0, 0, 0);
    checkOutput(F_SET, 2); checkOutput(F_CYC, 1);

    // en dropped then restored: no compare while idle or priming
    step(1, 0, 0, 0, 1, 0, 1, 0);
    checkOutput(F_SET, 2); checkOutput(F_CYC, 1);
    step(1, 1, 0, 0, 1, 0, 1, 0);
    checkOutput(F_SET, 3); checkOutput(F_CYC, 1); checkOutput(F_ERRCNT, 0);
    step(1, 1, 0, 0, 1, 0, 0, 0);
    checkOutput(F_SET, 4); checkOutput(F_CYC, 2);
    step(1, 1, 0, 0, 1, 0, 1, 1);
    checkOutput(F_ERRCNT, 1); checkOutput(F_FECYC, 2); checkOutput(F_FEEXP, 1);
    checkOutput(F_STICKY, 1);
    step(1, 1, 0, 0, 1, 0, 0, 0);

    // Let the monitor drain, bounded
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
    #5;
    while (sb.size() > 0) begin
      exp_t item;
      item = sb.pop_front();
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain %s: got unchecked, expected checked at edge %0d",
               item.f.name(), item.cyc);
    end

    // Final state: first-error capture from the last fault is retained
    tests_run++;
    if (err_cnt !== 8'd1) begin
      tests_failed++;
      $display("[TB] FAIL final err_cnt: got %0d, expected 1", err_cnt);
    end
    tests_run++;
    if (err_sticky !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL final err_sticky: got %0d, expected 1", err_sticky);
    end
    tests_run++;
    if (fe_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL final fe_valid: got %0d, expected 1", fe_valid);
    end
    tests_run++;
    if (fe_cycle !== 16'd2) begin
      tests_failed++;
      $display("[TB] FAIL final fe_cycle: got %0d, expected 2", fe_cycle);
    end
    tests_run++;
    if (fe_exp !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL final fe_exp: got %0d, expected 1", fe_exp);
    end
    tests_run++;
    if (err_pulse !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL final err_pulse: got %0d, expected 0", err_pulse);
    end
    tests_run++;
    if (cnt_reset !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL final cnt_reset: got %0d, expected 0", cnt_reset);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/jkff_monitor.md
# jkff_monitor

Passive checker for the JK flip-flop (`jkff_nbk`). Every clock it samples the flip-flop's J, K, reset and Q, predicts the next Q from the JK characteristic, and flags any mismatch. It also counts how often each J/K mode is applied and captures the first failure. It sits beside `jkff_nbk` in benches and on-chip self-test and never drives the flip-flop.

## Interface
- `CNT_W`, default 8: width of the four mode counters and the error counter; all saturate.
- `CYC_W`, default 16: width of the checked-cycle counter and the first-error cycle stamp.

Ports (name, direction, width, meaning):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset of the monitor only.
- `en`  in  1  checking enable; low forces IDLE.
- `clr`  in  1  synchronous clear of counters and first-error capture; FSM is unaffected.
- `dut_rst`  in  1  the monitored flip-flop's active-high reset.
- `J`, `K`  in  1 each  the monitored flip-flop's inputs.
- `Q`  in  1  the monitored flip-flop's output.
- `err_pulse`  out  1  high for one cycle per detected mismatch.
- `err_sticky`  out  1  set on the first mismatch; cleared only by `rst` or `clr`.
- `err_cnt`  out  CNT_W  mismatch count.
- `cnt_hold`, `cnt_reset`, `cnt_set`, `cnt_toggle`  out  CNT_W each  counts of applied J/K = 00, 01, 10, 11.
- `cyc_cnt`  out  CYC_W  number of CHECK cycles.
- `fe_valid`  out  1  first-error fields are valid.
- `fe_cycle`  out  CYC_W  `cyc_cnt` value at the first mismatch.
- `fe_exp`  out  1  expected Q at the first mismatch (observed Q is its inverse).

## Operation
- States:
  - IDLE: no compare, no counting.
  - PRIME: first enabled edge; computes the expectation but does no compare.
  - CHECK: compares on every edge.
- Transitions:
  - IDLE→PRIME when `en`=1.
  - PRIME→CHECK unconditionally, provided `en` stays 1.
  - Any state→IDLE when `en`=0. The expectation is discarded, so re-entry passes through PRIME again.
- Prediction at each edge in PRIME or CHECK:
  - `exp_q` ← 0 if `dut_rst`=1.
  - Otherwise `exp_q` ← {J,K}: 00→Q, 01→0, 10→1, 11→~Q.
  - The prediction uses the observed Q, not the previous prediction, so a single fault yields exactly one error.
- Compare at each CHECK edge: mismatch when Q ≠ `exp_q`.
- Mode counting: in PRIME/CHECK edges with `dut_rst`=0, increment the counter selected by {J,K}. Edges with `dut_rst`=1 count no mode.
- `cyc_cnt` increments on every CHECK edge.
- All counters saturate at their all-ones value and do not wrap.
- First error: on a mismatch with `fe_valid`=0, latch `fe_cycle` ← current `cyc_cnt` (pre-increment) and `fe_exp`, then set `fe_valid`. Later mismatches do not overwrite.
- `clr`=1 at an edge:
  - Zeroes all counters, `err_sticky` and the fe_* fields.
  - Any mode or error event at that same edge is dropped from the counters and sticky state; `err_pulse` still fires for it.
- `rst`=0 at an edge: every output goes to 0 and the FSM goes to IDLE, including mid-CHECK. `rst` has priority over `en` and `clr`.

## Timing
- Reset values: every output is 0 and the FSM is IDLE.
- Mismatch latency: J/K applied at edge n, the flip-flop's Q is compared at edge n+1, and `err_pulse`, `err_cnt`, `err_sticky` and fe_* update at that same edge n+1 (registered outputs).
- Mode counters update at the edge the J/K is sampled.
- `en` rising at edge n: PRIME at n, first compare at n+1.
- `dut_rst` and J/K both active at the same edge: reset wins, exp_q=0.

## Structure
- Package `jkff_pkg`:
  - Mode encoding HOLD=2'b00, RST=2'b01, SET=2'b10, TGL=2'b11.
  - FSM state typedef (IDLE/PRIME/CHECK).
  - Function `jk_next(q, j, k)`.
- Sub-module `jkff_sat_cnt` (parameter W; inputs `inc`, `clr`; output `cnt`) is natural and is instantiated six times.

## Test plan
Correct `jkff_nbk`, 20 ns clock period, `en`=1 throughout; input phases are 40 ns each.

- **Clean run.**
  - Stimulus: `dut_rst` 40 ns, then J/K = 00, 01, 10, 11 (40 ns each).
  - Required response: `err_cnt`=0, `cnt_hold`=2, `cnt_reset`=2, `cnt_set`=2, `cnt_toggle`=2, `fe_valid`=0.
- **Single fault.**
  - Stimulus: force Q inverted for one cycle during J/K=10.
  - Required response: exactly one `err_pulse`, `err_cnt`=1, `fe_exp`=1, `fe_cycle` equals the cycle index of the fault.
- **Toggle chain.**
  - Stimulus: J/K=11 for 10 edges.
  - Required response: Q alternates, no errors, `cnt_toggle`=10.
- **Saturation.**
  - Stimulus: `CNT_W`=2, 6 hold edges.
  - Required response: `cnt_hold`=3 and stays at 3.
- **clr collision.**
  - Stimulus: `clr` at the same edge as a forced mismatch.
  - Required response: `err_pulse`=1, while `err_cnt`=0 and `err_sticky`=0 after the edge.
- **Mid-run reset and en drop.**
  - Stimulus: `rst`=0 during CHECK, then `en` toggled 1→0→1.
  - Required response: all outputs go to 0; no compare on the first re-enabled edge.
